// File: rtl/controle_desvio_if.sv
// Handshake bundle between decode / ULA-comparison path / PC register and
// the branch/jump controller.
interface controle_desvio_if #(
    parameter int LARGURA_END = 32
);
    logic                   req_desvio;
    logic [1:0]             tipo_desvio;
    logic [LARGURA_END-1:0] pc_atual;
    logic [LARGURA_END-1:0] alvo;
    logic                   ula_valida;
    logic                   resultado_comparacao;
    logic                   ula_op_sub;
    logic                   branch_tipo;
    logic                   ocupado;
    logic                   pc_escrita;
    logic [LARGURA_END-1:0] pc_novo;
    logic                   flush;
    logic                   escreve_link;
    logic [LARGURA_END-1:0] endereco_link;
    logic                   erro_timeout;
    logic [15:0]            desvios_tomados;

    // Datapath side: presents requests and the comparison verdict.
    modport master (
        output req_desvio, tipo_desvio, pc_atual, alvo, ula_valida, resultado_comparacao,
        input  ula_op_sub, branch_tipo, ocupado, pc_escrita, pc_novo, flush,
               escreve_link, endereco_link, erro_timeout, desvios_tomados
    );

    // Controller side.
    modport slave (
        input  req_desvio, tipo_desvio, pc_atual, alvo, ula_valida, resultado_comparacao,
        output ula_op_sub, branch_tipo, ocupado, pc_escrita, pc_novo, flush,
               escreve_link, endereco_link, erro_timeout, desvios_tomados
    );
endinterface

// File: rtl/controle_desvio.sv
// Multicycle branch/jump controller: accepts one transfer, waits for the
// ULA comparison on conditional branches, then issues a single PC update
// with flush/link pulses. Stalls the front end while a transfer is active.
module controle_desvio #(
    parameter int LARGURA_END   = 32,
    parameter int LIMITE_ESPERA = 8
) (
    input  logic             clock,
    input  logic             reset,
    controle_desvio_if.slave bus
);
    localparam int CW = (LIMITE_ESPERA > 1) ? $clog2(LIMITE_ESPERA) : 1;
    localparam logic [CW-1:0]          ESPERA_MAX = CW'(LIMITE_ESPERA - 1);
    localparam logic [CW-1:0]          ESPERA_UM  = CW'(1);
    localparam logic [LARGURA_END-1:0] QUATRO     = LARGURA_END'(4);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        AGUARDA_ULA = 2'd1,
        ATUALIZA    = 2'd2
    } estado_t;

    estado_t                estado_q, estado_d;
    logic [1:0]             tipo_q, tipo_d;
    logic [LARGURA_END-1:0] pc_q, pc_d;
    logic [LARGURA_END-1:0] alvo_q, alvo_d;
    logic                   tomado_q, tomado_d;
    logic                   timeout_q, timeout_d;
    logic [CW-1:0]          espera_q, espera_d;
    logic [LARGURA_END-1:0] pc_novo_q, pc_novo_d;
    logic [LARGURA_END-1:0] link_q, link_d;
    logic [15:0]            desvios_q, desvios_d;

    // State register and all latched transfer context.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= OCIOSO;
            tipo_q    <= 2'b00;
            pc_q      <= '0;
            alvo_q    <= '0;
            tomado_q  <= 1'b0;
            timeout_q <= 1'b0;
            espera_q  <= '0;
            pc_novo_q <= '0;
            link_q    <= '0;
            desvios_q <= 16'h0000;
        end else begin
            estado_q  <= estado_d;
            tipo_q    <= tipo_d;
            pc_q      <= pc_d;
            alvo_q    <= alvo_d;
            tomado_q  <= tomado_d;
            timeout_q <= timeout_d;
            espera_q  <= espera_d;
            pc_novo_q <= pc_novo_d;
            link_q    <= link_d;
            desvios_q <= desvios_d;
        end
    end

    // Next-state logic; pc_novo is computed on the way into ATUALIZA so it
    // is already registered when pc_escrita is decoded.
    always_comb begin
        estado_d  = estado_q;
        tipo_d    = tipo_q;
        pc_d      = pc_q;
        alvo_d    = alvo_q;
        tomado_d  = tomado_q;
        timeout_d = timeout_q;
        espera_d  = espera_q;
        pc_novo_d = pc_novo_q;
        link_d    = link_q;
        desvios_d = desvios_q;
        case (estado_q)
            OCIOSO: begin
                if (bus.req_desvio) begin
                    tipo_d    = bus.tipo_desvio;
                    pc_d      = bus.pc_atual;
                    alvo_d    = bus.alvo;
                    link_d    = bus.pc_atual + QUATRO;
                    timeout_d = 1'b0;
                    espera_d  = '0;
                    if (bus.tipo_desvio[1]) begin
                        tomado_d  = 1'b1;
                        pc_novo_d = bus.alvo;
                        estado_d  = ATUALIZA;
                    end else begin
                        tomado_d  = 1'b0;
                        estado_d  = AGUARDA_ULA;
                    end
                end else begin
                    estado_d = OCIOSO;
                end
            end
            AGUARDA_ULA: begin
                if (bus.ula_valida) begin
                    tomado_d  = bus.resultado_comparacao;
                    pc_novo_d = bus.resultado_comparacao ? alvo_q : (pc_q + QUATRO);
                    estado_d  = ATUALIZA;
                end else if (espera_q == ESPERA_MAX) begin
                    tomado_d  = 1'b0;
                    timeout_d = 1'b1;
                    pc_novo_d = pc_q + QUATRO;
                    estado_d  = ATUALIZA;
                end else begin
                    espera_d  = espera_q + ESPERA_UM;
                end
            end
            ATUALIZA: begin
                estado_d = OCIOSO;
                if (tomado_q && (desvios_q != 16'hFFFF)) begin
                    desvios_d = desvios_q + 16'd1;
                end else begin
                    desvios_d = desvios_q;
                end
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // Moore decodes of the registered state.
    assign bus.ocupado         = (estado_q != OCIOSO);
    assign bus.ula_op_sub      = (estado_q == AGUARDA_ULA);
    assign bus.branch_tipo     = (estado_q == AGUARDA_ULA) & tipo_q[0];
    assign bus.pc_escrita      = (estado_q == ATUALIZA);
    assign bus.flush           = (estado_q == ATUALIZA) & tomado_q;
    assign bus.escreve_link    = (estado_q == ATUALIZA) & (tipo_q == 2'b11);
    assign bus.erro_timeout    = (estado_q == ATUALIZA) & timeout_q;
    assign bus.pc_novo         = pc_novo_q;
    assign bus.endereco_link   = link_q;
    assign bus.desvios_tomados = desvios_q;
endmodule

// File: doc/controle_desvio.md
# controle_desvio

Multicycle branch/jump controller for the processor datapath. Accepts one control-transfer request from decode and, for conditional branches, has the ULA compute a subtraction. It drives the comparison unit's branch type, samples its one-bit verdict, then issues a single PC update with flush and link-write pulses. It sits between decode, the ULA/comparison path and the PC register, and stalls the front end while a transfer is in flight.

## Interface
- LARGURA_END, 32: PC/address width (≥ 8).
- LIMITE_ESPERA, 8: max cycles in AGUARDA_ULA before timeout (≥ 1).
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately.
- req_desvio  in  1  decode presents a transfer this cycle.
- tipo_desvio  in  2  00 beq, 01 bne, 10 jump, 11 jal.
- pc_atual  in  LARGURA_END  PC of the transfer instruction.
- alvo  in  LARGURA_END  target address, precomputed by decode.
- ula_valida  in  1  ULA result and comparison verdict valid this cycle.
- resultado_comparacao  in  1  comparison unit output (1 = condition met).
- ula_op_sub  out  1  request ULA subtraction of branch operands.
- branch_tipo  out  1  to comparison unit: 0 = equal-zero test, 1 = not-zero test.
- ocupado  out  1  front-end stall.
- pc_escrita  out  1  one-cycle PC write enable.
- pc_novo  out  LARGURA_END  next PC, valid while pc_escrita = 1.
- flush  out  1  one-cycle squash of the fetched instruction.
- escreve_link  out  1  one-cycle register-file write for jal.
- endereco_link  out  LARGURA_END  link value (pc_atual + 4).
- erro_timeout  out  1  one-cycle pulse on ULA timeout.
- desvios_tomados  out  16  saturating count of taken transfers.

## Operation
- FSM states: OCIOSO, AGUARDA_ULA, ATUALIZA. Reset state is OCIOSO.
- OCIOSO with req_desvio = 1:
  - Latch tipo_desvio, pc_atual and alvo.
  - tipo 0x goes to AGUARDA_ULA and clears the wait counter.
  - tipo 1x goes to ATUALIZA with tomado = 1.
- OCIOSO with req_desvio = 0: stay in OCIOSO.
- AGUARDA_ULA:
  - ula_op_sub = 1; branch_tipo = latched tipo[0].
  - If ula_valida = 1: tomado <= resultado_comparacao; go to ATUALIZA.
  - Otherwise increment the wait counter. When the counter reaches LIMITE_ESPERA - 1 without ula_valida, set tomado <= 0, set the timeout flag, and go to ATUALIZA.
- ATUALIZA (exactly one cycle, then OCIOSO):
  - pc_escrita = 1.
  - pc_novo = tomado ? alvo : pc+4.
  - flush = tomado.
  - escreve_link = (tipo == 11).
  - erro_timeout = timeout flag.
  - If tomado = 1, desvios_tomados increments and saturates at 0xFFFF.
- Arithmetic: pc+4 is modulo 2^LARGURA_END, so 0xFFFFFFFC gives 0x00000000. endereco_link is held from latch time until the next accept.
- req_desvio is ignored outside OCIOSO. Decode must hold the request until ocupado falls.
- Output timing: pc_novo is registered. Pulse outputs are Moore decodes of ATUALIZA.
- ula_op_sub, pc_escrita, flush, escreve_link and erro_timeout are 0 in every state where they are not specified above.
- branch_tipo is 0 outside AGUARDA_ULA.
- Reset mid-operation returns the FSM to OCIOSO immediately. No pulse is emitted and the counter is cleared.

## Timing
- Reset values: all outputs 0, desvios_tomados 0, pc_novo 0, endereco_link 0.
- ocupado = 1 in AGUARDA_ULA and ATUALIZA, 0 in OCIOSO. It rises the cycle after accept.
- Jump/jal: req_desvio in cycle N gives pc_escrita in cycle N+1. Latency is 1 cycle.
- Branch: req_desvio in cycle N puts the FSM in AGUARDA_ULA from N+1. ula_valida in cycle M ≥ N+1 gives ATUALIZA in M+1. Minimum latency is 2 cycles.
- Timeout: with no ula_valida, ATUALIZA occurs in cycle N+1+LIMITE_ESPERA.
- A new request may be accepted in the cycle after ATUALIZA, so back-to-back transfers are spaced ≥ 2 cycles apart.

## Test plan
- beq, pc_atual=0x100, alvo=0x200, ula_valida with comparacao=1 two cycles later -> pc_escrita=1, pc_novo=0x200, flush=1, counter=1.
- bne, comparacao=0 at first AGUARDA_ULA cycle -> pc_novo=0x104, flush=0, counter unchanged; branch_tipo=1 during wait.
- jal, pc_atual=0xFFFFFFFC, alvo=0x40 -> next cycle pc_novo=0x40, escreve_link=1, endereco_link=0x00000000.
- beq with ula_valida held 0 and LIMITE_ESPERA=8 -> erro_timeout=1 in cycle N+9, pc_novo=pc+4, flush=0.
- Second req_desvio asserted while ocupado=1 -> ignored; accepted only in OCIOSO, one pc_escrita per accepted request.
- reset pulsed during AGUARDA_ULA -> ocupado=0 immediately, no pc_escrita; counter forced to 0xFFFF by 65535+ taken jumps stays 0xFFFF.
